// File: rtl/xdisplay_scan_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package xdisplay_scan_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NDIG   = 4;
    localparam int unsigned IDX_W  = 2;

    localparam logic [ADDR_W-1:0] ADDR_CTRL = 3'd4;
    localparam logic [DATA_W-1:0] SEG_BLANK = 8'hFF;
    localparam logic [NDIG-1:0]   AN_OFF    = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // Per-digit value register: 4-bit value plus decimal point.
    typedef struct packed {
        logic       dp;
        logic [3:0] val;
    } digit_t;

    // Control register: digit mask plus scan enable.
    typedef struct packed {
        logic [3:0] mask;
        logic       en;
    } ctrl_t;

    // Bus view of CTRL; bits [3:1] read as zero.
    function automatic logic [DATA_W-1:0] ctrl_to_byte(input ctrl_t c);
        return {c.mask, 3'b000, c.en};
    endfunction

endpackage

// File: rtl/xdisplay_scan_if.sv
// Peripheral bus between CPU and display controller.
interface xdisplay_scan_if;
    import xdisplay_scan_pkg::*;

    logic              sel;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (output sel, output we, output addr, output data_in, input data_out);
    modport slave  (input sel, input we, input addr, input data_in, output data_out);

endinterface

// File: rtl/xdisplay_scan_seg_decode.sv
// Combinational digit value + dp to active-low segments {dp,g,f,e,d,c,b,a}.
module xdisplay_scan_seg_decode
    import xdisplay_scan_pkg::*;
(
    input  digit_t            i_digit,
    output logic [DATA_W-1:0] o_seg_c
);

    logic [6:0] w_pat;

    // Active-high segment pattern; values 10-15 stay dark.
    always_comb begin
        w_pat = 7'h00;
        case (i_digit.val)
            4'd0:    w_pat = 7'h3F;
            4'd1:    w_pat = 7'h06;
            4'd2:    w_pat = 7'h5B;
            4'd3:    w_pat = 7'h4F;
            4'd4:    w_pat = 7'h66;
            4'd5:    w_pat = 7'h6D;
            4'd6:    w_pat = 7'h7D;
            4'd7:    w_pat = 7'h07;
            4'd8:    w_pat = 7'h7F;
            4'd9:    w_pat = 7'h6F;
            default: w_pat = 7'h00;
        endcase
        o_seg_c = ~{i_digit.dp, w_pat};
    end

endmodule

// File: rtl/xdisplay_scan.sv
// Time-multiplexed 4-digit 7-segment display controller with blank gap per slot.
module xdisplay_scan
    import xdisplay_scan_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 1024,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned CNT_W        = 10
) (
    input  logic              clk,
    input  logic              rst,
    xdisplay_scan_if.slave    bus,
    output logic [NDIG-1:0]   an,
    output logic [DATA_W-1:0] seg
);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

    digit_t            r_digit [NDIG];
    ctrl_t             r_ctrl;
    logic [DATA_W-1:0] r_data_out;
    logic [DATA_W-1:0] w_rd;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;

    logic [NDIG-1:0]   r_an, w_an_nxt;
    logic [DATA_W-1:0] r_seg, w_seg_nxt;
    digit_t            w_dig_sel;
    logic [DATA_W-1:0] w_seg_dec;

    assign bus.data_out = r_data_out;
    assign an           = r_an;
    assign seg          = r_seg;

    // Read mux: digits expose only value+dp, unmapped addresses read zero.
    always_comb begin
        w_rd = '0;
        if (!bus.addr[2]) begin
            w_rd = DATA_W'(r_digit[bus.addr[1:0]]);
        end else if (bus.addr == ADDR_CTRL) begin
            w_rd = ctrl_to_byte(r_ctrl);
        end
    end

    // Register file writes and registered read data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NDIG); i++) begin
                r_digit[i] <= '0;
            end
            r_ctrl     <= '0;
            r_data_out <= '0;
        end else if (bus.sel && bus.we) begin
            if (!bus.addr[2]) begin
                r_digit[bus.addr[1:0]] <= bus.data_in[4:0];
            end else if (bus.addr == ADDR_CTRL) begin
                r_ctrl <= {bus.data_in[7:4], bus.data_in[0]};
            end
        end else if (bus.sel) begin
            r_data_out <= w_rd;
        end
    end

    // FSM state and slot counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next state: blank gap, then show until slot end, then advance digit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        if (!r_ctrl.en) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
                ST_BLANK: begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == BLANK_LAST) begin
                        w_state_nxt = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == SLOT_LAST) begin
                        w_state_nxt = ST_BLANK;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = r_idx + IDX_W'(1);
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    assign w_dig_sel = r_digit[w_idx_nxt];

    xdisplay_scan_seg_decode u_dec (
        .i_digit (w_dig_sel),
        .o_seg_c (w_seg_dec)
    );

    // Outputs for the upcoming state; masked digits keep their slot dark.
    always_comb begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_BLANK;
        if (w_state_nxt == ST_SHOW) begin
            if (r_ctrl.mask[w_idx_nxt]) begin
                w_an_nxt[w_idx_nxt] = 1'b0;
            end
            w_seg_nxt = w_seg_dec;
        end
    end

    // Output registers, updated on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

endmodule

// File: tb/tb_xdisplay_scan.sv
// Self-checking bench for xdisplay_scan with a frame-position reference model.
module tb_xdisplay_scan;
    import xdisplay_scan_pkg::*;

    localparam int R = 8;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] an;
    logic [7:0] seg;
    int         n_chk  = 0;
    int         n_fail = 0;
    int         n_cyc  = 0;

    xdisplay_scan_if bus_if ();

    xdisplay_scan #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave),
        .an  (an),
        .seg (seg)
    );

    always #5 clk = ~clk;

    // Reference model: position within a 4*R frame, -1 when idle.
    logic [4:0] m_dig [4];
    logic [3:0] m_mask;
    logic       m_en;
    int         m_pos, m_slot, m_off;
    logic [3:0] e_an;
    logic [7:0] e_seg, e_dout;

    function automatic logic [7:0] seg_of(input logic [4:0] d);
        logic [6:0] p;
        case (d[3:0])
            4'd0: p = 7'h3F; 4'd1: p = 7'h06; 4'd2: p = 7'h5B; 4'd3: p = 7'h4F;
            4'd4: p = 7'h66; 4'd5: p = 7'h6D; 4'd6: p = 7'h7D; 4'd7: p = 7'h07;
            4'd8: p = 7'h7F; 4'd9: p = 7'h6F; default: p = 7'h00;
        endcase
        return ~{d[4], p};
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) m_dig[i] = 5'd0;
            m_mask = 4'd0; m_en = 1'b0; m_pos = -1;
            e_an = 4'hF; e_seg = 8'hFF; e_dout = 8'h00;
        end else begin
            if (!m_en)          m_pos = -1;
            else if (m_pos < 0) m_pos = 0;
            else                m_pos = (m_pos + 1) % (4 * R);
            e_an = 4'hF; e_seg = 8'hFF;
            if (m_pos >= 0) begin
                m_slot = m_pos / R;
                m_off  = m_pos % R;
                if (m_off >= B) begin
                    e_seg = seg_of(m_dig[m_slot]);
                    if (m_mask[m_slot]) e_an[m_slot] = 1'b0;
                end
            end
            if (bus_if.sel && !bus_if.we) begin
                if (bus_if.addr < 3'd4)       e_dout = {3'b000, m_dig[bus_if.addr[1:0]]};
                else if (bus_if.addr == 3'd4) e_dout = {m_mask, 3'b000, m_en};
                else                          e_dout = 8'h00;
            end
            if (bus_if.sel && bus_if.we) begin
                if (bus_if.addr < 3'd4) m_dig[bus_if.addr[1:0]] = bus_if.data_in[4:0];
                else if (bus_if.addr == 3'd4) begin
                    m_mask = bus_if.data_in[7:4];
                    m_en   = bus_if.data_in[0];
                end
            end
        end
    end

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock; every cycle compares an/seg/data_out against the model.
    task automatic tick();
        @(posedge clk);
        #1;
        n_cyc++;
        n_chk++;
        if ({an, seg, bus_if.data_out} !== {e_an, e_seg, e_dout}) begin
            n_fail++;
            $display("FAIL scan cyc %0d: got an=%h seg=%h dout=%h expected an=%h seg=%h dout=%h",
                     n_cyc, an, seg, bus_if.data_out, e_an, e_seg, e_dout);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        bus_if.sel = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.data_in = d;
        tick();
        bus_if.sel = 1'b0; bus_if.we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a);
        bus_if.sel = 1'b1; bus_if.we = 1'b0; bus_if.addr = a;
        tick();
        bus_if.sel = 1'b0;
    endtask

    typedef struct {
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] rexp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{3'd0, 8'hFF, 8'h1F};
        vecs[1] = '{3'd1, 8'hA5, 8'h05};
        vecs[2] = '{3'd2, 8'h3C, 8'h1C};
        vecs[3] = '{3'd3, 8'hE0, 8'h00};
        vecs[4] = '{3'd4, 8'hFE, 8'hF0};
        vecs[5] = '{3'd4, 8'h8B, 8'h81};
        vecs[6] = '{3'd5, 8'hFF, 8'h00};
        vecs[7] = '{3'd6, 8'h12, 8'h00};
        vecs[8] = '{3'd7, 8'hAB, 8'h00};
        vecs[9] = '{3'd4, 8'h00, 8'h00};

        bus_if.sel = 1'b0; bus_if.we = 1'b0; bus_if.addr = 3'd0; bus_if.data_in = 8'h00;

        // Reset held 3 cycles, then all reads return zero.
        rst = 1'b0;
        repeat (3) tick();
        check8("reset_an", {4'h0, an}, 8'h0F);
        check8("reset_seg", seg, 8'hFF);
        rst = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a));
            check8($sformatf("reset_read%0d", a), bus_if.data_out, 8'h00);
        end

        // Register write/readback table.
        for (int i = 0; i < 10; i++) begin
            bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr);
            check8($sformatf("regvec%0d", i), bus_if.data_out, vecs[i].rexp);
        end
        repeat (2) tick();

        // Digits 1,2,3,4 with all digits enabled.
        for (int d = 0; d < 4; d++) bus_write(3'(d), 8'(d + 1));
        bus_write(3'd4, 8'hF1);
        for (int j = 1; j <= 35; j++) begin
            tick();
            if (j == 2 || j == 9) begin
                check8("t2_blank_an", {4'h0, an}, 8'h0F);
                check8("t2_blank_seg", seg, 8'hFF);
            end
            if (j == 3 || j == 8 || j == 35) begin
                check8("t2_d0_an", {4'h0, an}, 8'h0E);
                check8("t2_d0_seg", seg, 8'hF9);
            end
            if (j == 11) begin
                check8("t2_d1_an", {4'h0, an}, 8'h0D);
                check8("t2_d1_seg", seg, 8'hA4);
            end
        end

        // Mask digits 1 and 3: their slots stay dark, period unchanged.
        bus_write(3'd4, 8'h00);
        bus_write(3'd4, 8'h51);
        for (int j = 1; j <= 35; j++) begin
            tick();
            if ((j >= 9 && j <= 16) || (j >= 25 && j <= 32))
                check8($sformatf("t3_masked_an_j%0d", j), {4'h0, an}, 8'h0F);
            if (j == 19 || j == 24)
                check8("t3_d2_an", {4'h0, an}, 8'h0B);
            if (j == 35)
                check8("t3_wrap_an", {4'h0, an}, 8'h0E);
        end

        // Blank value with dp, and value 15 blank.
        bus_write(3'd4, 8'h00);
        bus_write(3'd2, 8'h1A);
        bus_write(3'd0, 8'h0F);
        bus_write(3'd4, 8'hF1);
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (j == 3) begin
                check8("t4_d0_an", {4'h0, an}, 8'h0E);
                check8("t4_d0_seg", seg, 8'hFF);
            end
            if (j == 19) begin
                check8("t4_d2_an", {4'h0, an}, 8'h0B);
                check8("t4_d2_seg", seg, 8'h7F);
            end
        end

        // Disable mid-show of digit 2, then restart from digit 0.
        bus_write(3'd4, 8'h00);
        check8("t5_still_on", {4'h0, an}, 8'h0B);
        tick();
        check8("t5_off_an", {4'h0, an}, 8'h0F);
        bus_write(3'd4, 8'hF1);
        for (int j = 1; j <= 5; j++) begin
            tick();
            if (j == 2) check8("t5_restart_blank", {4'h0, an}, 8'h0F);
            if (j == 3) check8("t5_restart_d0", {4'h0, an}, 8'h0E);
        end

        // Reset mid-show.
        rst = 1'b0;
        tick();
        check8("t6_rst_an", {4'h0, an}, 8'h0F);
        check8("t6_rst_seg", seg, 8'hFF);
        rst = 1'b1;
        bus_read(3'd4);
        check8("t6_ctrl_read", bus_if.data_out, 8'h00);
        bus_read(3'd2);
        check8("t6_dig2_read", bus_if.data_out, 8'h00);

        // Randomized bus traffic against the model.
        bus_write(3'd4, 8'hF1);
        for (int c = 0; c < 3000; c++) begin
            bus_if.sel     = ($urandom_range(0, 3) == 0);
            bus_if.we      = $urandom_range(0, 1) == 1;
            bus_if.addr    = 3'($urandom_range(0, 7));
            bus_if.data_in = 8'($urandom);
            if (bus_if.addr == 3'd4) bus_if.data_in[0] = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 599) != 0);
            tick();
        end
        bus_if.sel = 1'b0;
        rst = 1'b1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
